// File: rtl/top.sv
// 128x96 monochrome bitmap fed over a write-only SPI slave and scanned out as 640x480@60 Hz VGA.
// Each bitmap pixel is replicated 5x5. Everything runs in the single pixel-clock domain.
`timescale 1ns/1ps

module vga_timing (
  input  logic       Clock,
  input  logic       Reset,
  output logic [9:0] HCounter,
  output logic [9:0] VCounter
);

  // raster position: 800 clocks per line, 525 lines per frame
  always_ff @(posedge Clock) begin
    if (Reset) begin
      HCounter <= 10'd0;
      VCounter <= 10'd0;
    end else if (HCounter == 10'd799) begin
      HCounter <= 10'd0;
      VCounter <= (VCounter == 10'd524) ? 10'd0 : VCounter + 10'd1;
    end else begin
      HCounter <= HCounter + 10'd1;
    end
  end

endmodule

module bitmap_ram #(
  parameter int DEPTH = 1536,
  parameter int AW    = 11
) (
  input  logic          Clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] Memory [0:DEPTH-1];

  // one write port from SPI, one registered read port for the scan-out
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      Memory[wr_addr] <= wr_data;
    end
    rd_data <= Memory[rd_addr];
  end

endmodule

module top #(
  parameter int CLOCK_HZ = 25_175_000,
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 96,
  parameter int SCALE    = 5
) (
  input  logic Clock,
  input  logic Reset,
  input  logic CS_i,
  input  logic SCK_i,
  input  logic MOSI_i,
  input  logic DC_i,
  output logic HSync_o,
  output logic VSync_o,
  output logic Red_o,
  output logic Green_o,
  output logic Blue_o
);

  localparam int MEM_BYTES = WIDTH * HEIGHT / 8;
  localparam int ROW_BYTES = WIDTH / 8;
  localparam int AW        = $clog2(MEM_BYTES);
  localparam int H_VIS     = WIDTH * SCALE;
  localparam int V_VIS     = HEIGHT * SCALE;

  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;

  if (CLOCK_HZ <= 0) begin : g_clock_hz_invalid
  end

  logic [9:0]    HCounter;
  logic [9:0]    VCounter;

  logic [1:0]    cs_sync_r;
  logic [1:0]    sck_sync_r;
  logic [1:0]    mosi_sync_r;
  logic [1:0]    dc_sync_r;
  logic          sck_prev_r;
  logic          sck_rise_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic [AW-1:0] ptr_r;
  logic          wr_en_r;
  logic [AW-1:0] wr_addr_r;
  logic [7:0]    wr_data_r;

  logic          visible_s;
  logic          hsync_s;
  logic          vsync_s;
  logic [6:0]    bx_s;
  logic [6:0]    by_s;
  logic [AW-1:0] rd_addr_s;
  logic [7:0]    rd_data_s;
  logic          vis_p1_r;
  logic          hs_p1_r;
  logic          vs_p1_r;
  logic [2:0]    bit_sel_p1_r;
  logic          pixel_s;

  vga_timing VGA_inst (
    .Clock    (Clock),
    .Reset    (Reset),
    .HCounter (HCounter),
    .VCounter (VCounter)
  );

  bitmap_ram #(
    .DEPTH (MEM_BYTES),
    .AW    (AW)
  ) BitmapRAM (
    .Clock   (Clock),
    .wr_en   (wr_en_r),
    .wr_addr (wr_addr_r),
    .wr_data (wr_data_r),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // two-flop synchronisers for the SPI pins plus the previous SCK sample
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cs_sync_r   <= 2'b11;
      sck_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      dc_sync_r   <= 2'b00;
      sck_prev_r  <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[0], CS_i};
      sck_sync_r  <= {sck_sync_r[0], SCK_i};
      mosi_sync_r <= {mosi_sync_r[0], MOSI_i};
      dc_sync_r   <= {dc_sync_r[0], DC_i};
      sck_prev_r  <= sck_sync_r[1];
    end
  end

  assign sck_rise_s = sck_sync_r[1] & ~sck_prev_r;

  // byte assembly; DC travels through the same synchroniser depth as SCK so it matches the 8th bit
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      ptr_r     <= {AW{1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= 8'd0;
    end else begin
      wr_en_r <= 1'b0;
      if (cs_sync_r[1]) begin
        bit_cnt_r <= 3'd0;
        ptr_r     <= {AW{1'b0}};
      end else if (sck_rise_s) begin
        shift_r   <= {shift_r[6:0], mosi_sync_r[1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if ((bit_cnt_r == 3'd7) && dc_sync_r[1]) begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= ptr_r;
          wr_data_r <= {shift_r[6:0], mosi_sync_r[1]};
          ptr_r     <= (ptr_r == AW'(MEM_BYTES - 1)) ? {AW{1'b0}} : ptr_r + AW'(1);
        end
      end
    end
  end

  // raster position -> bitmap byte address and sync levels
  always_comb begin
    visible_s = (HCounter < 10'(H_VIS)) && (VCounter < 10'(V_VIS));
    bx_s      = 7'(HCounter / 10'(SCALE));
    by_s      = 7'(VCounter / 10'(SCALE));
    hsync_s   = !((HCounter >= H_SYNC_FIRST) && (HCounter <= H_SYNC_LAST));
    vsync_s   = !((VCounter >= V_SYNC_FIRST) && (VCounter <= V_SYNC_LAST));
    if (visible_s) begin
      rd_addr_s = AW'(by_s) * AW'(ROW_BYTES) + AW'(bx_s[6:3]);
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
  end

  // stage 1 runs alongside the RAM read so both land in the same cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vis_p1_r     <= 1'b0;
      hs_p1_r      <= 1'b1;
      vs_p1_r      <= 1'b1;
      bit_sel_p1_r <= 3'd0;
    end else begin
      vis_p1_r     <= visible_s;
      hs_p1_r      <= hsync_s;
      vs_p1_r      <= vsync_s;
      bit_sel_p1_r <= 3'd7 - bx_s[2:0];
    end
  end

  assign pixel_s = vis_p1_r & rd_data_s[bit_sel_p1_r];

  // stage 2: registered pins, two clocks behind the counters
  always_ff @(posedge Clock) begin
    if (Reset) begin
      HSync_o <= 1'b1;
      VSync_o <= 1'b1;
      Red_o   <= 1'b0;
      Green_o <= 1'b0;
      Blue_o  <= 1'b0;
    end else begin
      HSync_o <= hs_p1_r;
      VSync_o <= vs_p1_r;
      Red_o   <= pixel_s;
      Green_o <= pixel_s;
      Blue_o  <= pixel_s;
    end
  end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the SPI bitmap display: a predictor queues expected pin values per clock,
// a monitor pops and compares them line by line; SPI writes are checked against a byte-level model.
`timescale 1ns/1ps

module tb_top;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic CS_i = 1'b1;
  logic SCK_i = 1'b0;
  logic MOSI_i = 1'b0;
  logic DC_i = 1'b1;
  logic HSync_o, VSync_o, Red_o, Green_o, Blue_o;

  top dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .CS_i    (CS_i),
    .SCK_i   (SCK_i),
    .MOSI_i  (MOSI_i),
    .DC_i    (DC_i),
    .HSync_o (HSync_o),
    .VSync_o (VSync_o),
    .Red_o   (Red_o),
    .Green_o (Green_o),
    .Blue_o  (Blue_o)
  );

  always #20 Clock = ~Clock;

  typedef struct {
    bit       hs;
    bit       vs;
    bit [2:0] rgb;
    bit       care_col;
    int       h;
    int       v;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] mem_m [0:1535];
  int         ptr_m = 0;
  bit         quiet = 1'b0;
  int         k = 0;

  // expected pins during clock n after reset release (outputs lag the raster by 2 clocks)
  function automatic exp_t predict(input int n);
    exp_t e;
    int p, bx, by;
    logic [7:0] byte_v;
    bit vis, pix;
    e.hs = 1'b1; e.vs = 1'b1; e.rgb = 3'b000; e.care_col = 1'b1; e.h = -1; e.v = -1;
    if (n >= 2) begin
      p   = n - 2;
      e.h = p % 800;
      e.v = (p / 800) % 525;
      e.hs = !(e.h >= 656 && e.h < 656 + 96);
      e.vs = !(e.v == 490 || e.v == 491);
      vis = (e.h < 640) && (e.v < 480);
      pix = 1'b0;
      if (vis) begin
        bx = e.h / 5;
        by = e.v / 5;
        byte_v = mem_m[by * 16 + bx / 8];
        pix = byte_v[7 - (bx % 8)];
      end
      e.rgb = pix ? 3'b111 : 3'b000;
      e.care_col = quiet || !vis;
    end
    return e;
  endfunction

  // predictor: one expectation per clock after reset
  always @(posedge Clock) begin
    if (Reset) begin
      k <= 0;
    end else begin
      k <= k + 1;
      exp_q.push_back(predict(k + 1));
    end
  end

  int  line_err = 0;
  int  bad_h = 0;
  logic [4:0] bad_act = 5'd0, bad_req = 5'd0;
  int  hs_low = 0;

  // monitor: compare every clock, report once per raster line and per HSync pulse
  always @(negedge Clock) begin
    exp_t e;
    logic [4:0] act, req;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {HSync_o, VSync_o, Red_o, Green_o, Blue_o};
      req = {e.hs, e.vs, e.rgb};
      if (!e.care_col) begin
        act[2:0] = 3'b000;
        req[2:0] = 3'b000;
      end
      if (act !== req) begin
        if (line_err == 0) begin
          bad_h = e.h; bad_act = act; bad_req = req;
        end
        line_err++;
      end
      if (e.h == 799) begin
        tests++;
        if (line_err != 0) begin
          fails++;
          $display("FAIL line%0d: %0d bad clocks, first at h=%0d got hs,vs,rgb=%b want %b",
                   e.v, line_err, bad_h, bad_act, bad_req);
        end
        line_err = 0;
      end
      if (HSync_o === 1'b0) begin
        hs_low++;
      end else if (hs_low > 0) begin
        tests++;
        if (hs_low != 96) begin
          fails++;
          $display("FAIL hsync_width: got %0d clocks low want 96", hs_low);
        end
        hs_low = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b, input logic dc);
    @(negedge Clock);
    SCK_i = 1'b0; MOSI_i = b; DC_i = dc;
    @(negedge Clock);
    SCK_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    if (dc) begin
      mem_m[ptr_m] = b;
      ptr_m = (ptr_m + 1) % 1536;
    end
  endtask

  task automatic spi_begin();
    quiet = 1'b0;
    ptr_m = 0;
    @(negedge Clock);
    CS_i = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic spi_end();
    @(negedge Clock);
    SCK_i = 1'b0;
    repeat (2) @(negedge Clock);
    CS_i = 1'b1;
    repeat (10) @(negedge Clock);
    quiet = 1'b1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] first1, last_b, b1535;
    for (int i = 0; i < 1536; i++) mem_m[i] = 8'h00;

    repeat (10) @(posedge Clock);
    @(negedge Clock);
    check("rst_hcounter", 32'(dut.VGA_inst.HCounter), 32'd0);
    check("rst_vcounter", 32'(dut.VGA_inst.VCounter), 32'd0);
    check("rst_sync", {30'd0, HSync_o, VSync_o}, 32'd3);
    check("rst_rgb", {29'd0, Red_o, Green_o, Blue_o}, 32'd0);
    Reset = 1'b0;

    // full white frame
    spi_begin();
    for (int i = 0; i < 1536; i++) send_byte(8'hFF, 1'b1);
    spi_end();
    check("fill_mem0", 32'(dut.BitmapRAM.Memory[0]), 32'hFF);
    check("fill_mem1", 32'(dut.BitmapRAM.Memory[1]), 32'hFF);
    check("fill_mem1534", 32'(dut.BitmapRAM.Memory[1534]), 32'hFF);
    check("fill_mem1535", 32'(dut.BitmapRAM.Memory[1535]), 32'hFF);
    repeat (1700) @(negedge Clock);

    // stripes over the first 16 bitmap rows
    spi_begin();
    for (int i = 0; i < 256; i++) send_byte((i % 2 == 0) ? 8'h55 : 8'hAA, 1'b1);
    spi_end();
    check("chk_mem0", 32'(dut.BitmapRAM.Memory[0]), 32'h55);
    check("chk_mem1", 32'(dut.BitmapRAM.Memory[1]), 32'hAA);
    repeat (1700) @(negedge Clock);

    // partial byte aborted by CS
    spi_begin();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    spi_end();
    spi_begin();
    send_byte(8'h3C, 1'b1);
    spi_end();
    check("abort_mem0", 32'(dut.BitmapRAM.Memory[0]), 32'h3C);
    check("abort_mem1", 32'(dut.BitmapRAM.Memory[1]), 32'hAA);

    // command byte is discarded and does not advance the pointer
    spi_begin();
    send_byte(8'hE7, 1'b0);
    send_byte(8'h81, 1'b1);
    spi_end();
    check("dc_mem0", 32'(dut.BitmapRAM.Memory[0]), 32'h81);
    check("dc_mem1", 32'(dut.BitmapRAM.Memory[1]), 32'hAA);

    // 1537 random bytes: the last one wraps onto address 0
    first1 = 8'h00; last_b = 8'h00; b1535 = 8'h00;
    spi_begin();
    for (int i = 0; i < 1537; i++) begin
      b = 8'($urandom);
      if (i == 1) first1 = b;
      if (i == 1535) b1535 = b;
      if (i == 1536) last_b = b;
      send_byte(b, 1'b1);
    end
    spi_end();
    check("wrap_mem0", 32'(dut.BitmapRAM.Memory[0]), 32'(last_b));
    check("wrap_mem1", 32'(dut.BitmapRAM.Memory[1]), 32'(first1));
    check("wrap_mem1535", 32'(dut.BitmapRAM.Memory[1535]), 32'(b1535));
    check("wrap_model0", 32'(dut.BitmapRAM.Memory[0]), 32'(mem_m[0]));
    repeat (2500) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
